// File: rtl/frame_rr_arbiter.sv
// frame_rr_arbiter: round-robin grant of NUM_REQ producers onto one
// registered 16-bit frame bus with backpressure hold and handshake count.
module frame_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic                      dup_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_frame,
  output logic [2:0]                out_src,
  output logic [15:0]               frame_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             ptr;
  logic [2:0]             grant;
  logic                   found;
  logic                   load;
  logic                   accept;
  logic [2*NUM_REQ-1:0]   rot;
  logic [DATA_W-1:0]      data_g;
  logic [TAG_W-1:0]       tag_g;
  logic [15:0]            frame_nxt;
  logic [2:0]             ptr_nxt;

  assign out_valid = (state == FULL);
  assign load      = !out_valid || out_ready;
  assign accept    = load && found;

  // Scan valids rotated so that ptr lands at bit 0; first hit wins
  always_comb begin
    int sum;
    found = 1'b0;
    grant = '0;
    sum   = 0;
    rot   = {req_valid, req_valid} >> ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        grant = 3'(sum);
      end
    end
  end

  // One-hot ready to the winner only when the output can load
  always_comb begin
    req_ready = '0;
    if (rst_n && accept)
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
  end

  // Build the candidate frame and the rotated pointer
  always_comb begin
    data_g    = req_data[int'(grant)*DATA_W +: DATA_W];
    tag_g     = req_tag[int'(grant)*TAG_W +: TAG_W];
    frame_nxt = dup_tag ? {data_g, tag_g, tag_g}
                        : {4'b0000, data_g, tag_g};
    ptr_nxt   = (grant == 3'(NUM_REQ-1)) ? 3'd0 : grant + 3'd1;
  end

  // Output register occupancy: refill or drain whenever load is open
  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = found ? FULL : EMPTY;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Frame, source and pointer update on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_frame <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_frame <= frame_nxt;
      out_src   <= grant;
      ptr       <= ptr_nxt;
    end
  end

  // Completed output handshake counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (out_valid && out_ready)
      frame_cnt <= frame_cnt + 16'd1;
  end

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// tb_frame_rr_arbiter: directed vectors with hand-computed frames,
// grants and handshake counts.
module tb_frame_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_data;
  logic [15:0] req_tag;
  logic        dup_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_frame;
  logic [2:0]  out_src;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  frame_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .TAG_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_tag(req_tag),
    .dup_tag(dup_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_frame(out_frame),
    .out_src(out_src),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    req_tag   = '0;
    dup_tag   = 1'b0;
    out_ready = 1'b0;
    #2;
    step();
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_frame", out_frame, 16'h0000);
    chk("rst_src",   16'(out_src), 16'd0);
    chk("rst_cnt",   frame_cnt, 16'd0);
    chk("rst_ready", 16'(req_ready), 16'd0);
    req_valid = 4'h0;
    rst_n     = 1'b1;
    #1;

    // single request
    req_valid = 4'b0001;
    req_data  = 32'h0000_00FA;
    req_tag   = 16'h0002;
    out_ready = 1'b1;
    #1;
    chk("single_ready", 16'(req_ready), 16'h0001);
    step();
    chk("single_frame", out_frame, 16'h0FA2);
    chk("single_src",   16'(out_src), 16'd0);
    chk("single_vld",   16'(out_valid), 16'd1);
    req_valid = 4'b0000;
    #1;
    chk("single_rdy0",  16'(req_ready), 16'h0000);
    step();
    chk("single_cnt",   frame_cnt, 16'd1);
    chk("single_empty", 16'(out_valid), 16'd0);

    // tag replication (ptr=1, scan wraps back to 0)
    req_valid = 4'b0001;
    dup_tag   = 1'b1;
    #1;
    chk("dup_ready", 16'(req_ready), 16'h0001);
    step();
    chk("dup_frame", out_frame, 16'hFA22);
    req_valid = 4'b0000;
    dup_tag   = 1'b0;
    step();
    chk("dup_cnt", frame_cnt, 16'd2);

    // round robin, all valid
    do_reset();
    chk("rr_cnt0", frame_cnt, 16'd0);
    req_data  = 32'hA3A2_A1A0;
    req_tag   = 16'h8765;
    req_valid = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_src", 16'(out_src), 16'(i % 4));
      chk("rr_frame", out_frame,
          {4'h0, 8'(8'hA0 + i % 4), 4'(5 + i % 4)});
    end
    req_valid = 4'h0;
    step();
    chk("rr_cnt8", frame_cnt, 16'd8);

    // backpressure on requester 1 (ptr=0)
    req_valid = 4'b0010;
    req_data  = 32'h0000_5C00;
    req_tag   = 16'h0070;
    out_ready = 1'b0;
    step();
    req_data  = 32'h0000_6D00;
    req_tag   = 16'h0080;
    for (int i = 0; i < 5; i++) begin
      chk("bp_frame", out_frame, 16'h05C7);
      chk("bp_src",   16'(out_src), 16'd1);
      chk("bp_ready", 16'(req_ready), 16'h0000);
      step();
    end
    chk("bp_cnt_hold", frame_cnt, 16'd8);
    out_ready = 1'b1;
    #1;
    chk("bp_regrant", 16'(req_ready), 16'h0002);
    step();
    chk("bp_cnt9",   frame_cnt, 16'd9);
    chk("bp_frame2", out_frame, 16'h06D8);
    chk("bp_vld",    16'(out_valid), 16'd1);
    req_valid = 4'h0;
    step();
    chk("bp_cnt10",  frame_cnt, 16'd10);
    chk("bp_empty",  16'(out_valid), 16'd0);

    // reset mid-operation with a pending frame
    req_valid = 4'b0100;
    req_data  = 32'h0011_0000;
    req_tag   = 16'h0300;
    out_ready = 1'b0;
    step();
    req_valid = 4'h0;
    chk("mid_pend", out_frame, 16'h0113);
    chk("mid_vld",  16'(out_valid), 16'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_vld0",   16'(out_valid), 16'd0);
    chk("mid_frame0", out_frame, 16'h0000);
    chk("mid_cnt0",   frame_cnt, 16'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("mid_restart", 16'(req_ready), 16'h0001);

    // counter wrap: requester 0 streaming
    req_valid = 4'b0001;
    req_data  = 32'h0000_0042;
    req_tag   = 16'h0001;
    out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    chk("wrap_ffff", frame_cnt, 16'hFFFF);
    step();
    chk("wrap_zero", frame_cnt, 16'h0000);
    chk("wrap_frame", out_frame, 16'h0421);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_rr_arbiter.md
# frame_rr_arbiter

Round-robin arbiter and framer that shares one output frame bus between NUM_REQ requesters. Each requester offers an 8-bit data byte and a 4-bit tag. The block grants one requester per cycle and builds a 16-bit frame from them, either as a zero-extended concatenation {data, tag} or as a tag-replicated frame {data, tag, tag}. It sits between the tag/data producers and the single downstream frame consumer, and holds each frame under backpressure.

## Interface
- NUM_REQ, 4, number of requesters (legal range 2..8)
- DATA_W, 8, data width per requester (fixed at 8 for this revision)
- TAG_W, 4, tag width per requester (fixed at 4 for this revision)
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  reset, asynchronous and active-low
- req_valid  input  NUM_REQ  per-requester valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_data  input  NUM_REQ*DATA_W  flattened data; requester i owns bits [i*8 +: 8]
- req_tag  input  NUM_REQ*TAG_W  flattened tags; requester i owns bits [i*4 +: 4]
- dup_tag  input  1  frame format select, sampled at accept
- out_valid  output  1  output frame valid
- out_ready  input  1  downstream accept
- out_frame  output  16  registered frame
- out_src  output  3  index of the requester that produced out_frame
- frame_cnt  output  16  count of completed output handshakes, wraps

## Operation
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition: load = !out_valid || out_ready.
- Arbitration (combinational, only when load=1):
  - Search req_valid starting at index ptr, then ptr+1, and so on, wrapping at NUM_REQ-1 to 0.
  - The first asserted index g wins, and req_ready[g]=1.
  - All other req_ready bits are 0.
  - When load=0, all req_ready bits are 0.
- On accept (load && |req_valid):
  - out_valid<=1.
  - out_src<=g.
  - ptr<=(g+1) mod NUM_REQ.
  - If dup_tag=0: out_frame <= {4'b0000, data_g, tag_g}.
  - If dup_tag=1: out_frame <= {data_g, tag_g, tag_g}.
- On load with no req_valid: out_valid<=0. out_frame and out_src keep their last values. ptr is unchanged.
- While out_valid && !out_ready: out_frame, out_src and out_valid are held stable. No grant is issued.
- frame_cnt increments by 1 on every cycle with out_valid && out_ready. It wraps from 16'hFFFF to 16'h0000.
- Requesters must hold valid, data and tag stable until their ready is seen. The arbiter uses data only in the accept cycle.
- A requester that drops valid before a grant is simply skipped. No error is flagged.
- dup_tag may change on any cycle. It affects only frames accepted in that cycle.

## Timing
- Reset values:
  - out_valid=0, out_frame=16'h0000, out_src=0, frame_cnt=0, ptr=0.
  - req_ready=0 while rst_n=0.
- Reset is asynchronous on assertion and synchronous on release.
- Latency: accept at edge N, out_valid=1 after edge N. First consumable at cycle N+1.
- Throughput: one frame per cycle when out_ready is held at 1 and any requester is valid.
- Simultaneous consume and accept: the old frame completes its handshake and the new frame loads at the same edge. out_valid stays 1 and frame_cnt increments.
- Fairness: any continuously valid requester is granted within NUM_REQ accepts.
- Reset mid-operation: a pending frame is discarded without handshake, and frame_cnt clears. Requesters see no ready and must re-present after reset.
- req_ready depends combinationally on req_valid, out_valid, out_ready and ptr. No other outputs are combinational.

## Test plan
- Single request:
  - Stimulus: reset, then req 0 only with data 8'hFA, tag 4'h2, dup_tag=0, out_ready=1.
  - Required response: req_ready=4'b0001 for one cycle. Next cycle out_frame=16'h0FA2, out_src=0, frame_cnt becomes 1 after the handshake.
- Tag replication:
  - Stimulus: same request as above with dup_tag=1.
  - Required response: out_frame=16'hFA22.
- Round-robin order:
  - Stimulus: all four requesters valid continuously, out_ready=1, 8 cycles.
  - Required response: out_src sequence 0,1,2,3,0,1,2,3 and frame_cnt=8.
- Backpressure:
  - Stimulus: req 1 valid, out_ready=0 for 5 cycles, then 1.
  - Required response: out_frame and out_src held for 5 cycles and req_ready=0 throughout. Then a single handshake, with req 1's next beat granted at the same edge.
- Counter wrap:
  - Stimulus: force 65536 handshakes.
  - Required response: frame_cnt returns to 16'h0000.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while out_valid=1 and out_ready=0.
  - Required response: out_valid, out_frame and frame_cnt are 0 immediately (asynchronous). After release, arbitration restarts at requester 0.
